// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder
// Passive responder for an HD44780-style LCD bus. It watches the E strobe,
// captures nibbles on E falling edges, tracks the 8-bit-mode initialisation
// and the switch to 4-bit mode, and assembles byte pairs. The resulting
// commands and data writes drive a small model of the controller state:
// cursor address, display-on bit and clear pulse.
//
// Ports
//   Clock               in   system clock, rising edge
//   Reset               in   synchronous active-high reset
//   iLCD_Enabled        in   LCD E strobe
//   iLCD_RegisterSelect in   0 = command, 1 = data
//   iLCD_ReadWrite      in   0 = write, 1 = read (read strobes are ignored)
//   iLCD_Data[3:0]      in   DB7..DB4
//   oByte[7:0]          out  last assembled byte
//   oIsData             out  register select of oByte
//   oByteValid          out  one-cycle pulse when oByte/oIsData update
//   oMode4Bit           out  4-bit interface established
//   oAddress[6:0]       out  DDRAM cursor address
//   oDisplayOn          out  display-on bit
//   oClearPulse         out  one-cycle pulse on clear-display
//   oProtocolError      out  sticky protocol error
//
// state | meaning
// INIT8 | 8-bit init phase, waiting for function-set nibble 0x2
// HI    | 4-bit mode, waiting for high nibble
// LO    | 4-bit mode, high nibble latched, waiting for low nibble
module lcd_bus_responder #(
  parameter int MIN_EN_HIGH    = 12,
  parameter int NIBBLE_TIMEOUT = 4095
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iLCD_Enabled,
  input  logic       iLCD_RegisterSelect,
  input  logic       iLCD_ReadWrite,
  input  logic [3:0] iLCD_Data,
  output logic [7:0] oByte,
  output logic       oIsData,
  output logic       oByteValid,
  output logic       oMode4Bit,
  output logic [6:0] oAddress,
  output logic       oDisplayOn,
  output logic       oClearPulse,
  output logic       oProtocolError
);

  localparam logic [1:0] INIT8 = 2'd0;
  localparam logic [1:0] HI    = 2'd1;
  localparam logic [1:0] LO    = 2'd2;

  localparam int HW = (MIN_EN_HIGH < 1) ? 1 : $clog2(MIN_EN_HIGH + 1);
  localparam int TW = (NIBBLE_TIMEOUT < 2) ? 1 : $clog2(NIBBLE_TIMEOUT + 1);
  localparam logic [HW-1:0] HIGH_MIN = HW'(MIN_EN_HIGH);
  localparam logic [TW-1:0] TO_MAX   = TW'(NIBBLE_TIMEOUT);
  localparam logic [TW-1:0] TO_LAST  = TW'((NIBBLE_TIMEOUT < 1) ? 0 : NIBBLE_TIMEOUT - 1);

  logic [1:0]    state;
  logic          enPrev;
  logic [HW-1:0] highCnt;
  logic [TW-1:0] timeoutCnt;
  logic [3:0]    hiNibble;
  logic          hiRs;

  logic       fallEdge;
  logic       writeStrobe;
  logic       validWrite;
  logic       shortWrite;
  logic [7:0] newByte;
  logic [6:0] addrInc;

  assign fallEdge    = enPrev & ~iLCD_Enabled;
  // Reads are ignored outright, so a short read pulse is not an error either.
  assign writeStrobe = fallEdge & ~iLCD_ReadWrite;
  assign validWrite  = writeStrobe & (highCnt >= HIGH_MIN);
  assign shortWrite  = writeStrobe & (highCnt < HIGH_MIN);
  assign newByte     = {hiNibble, iLCD_Data};

  // DDRAM line ends: line 1 runs 0x00-0x27, line 2 runs 0x40-0x67.
  always_comb begin
    addrInc = oAddress + 7'd1;
    if (oAddress == 7'h27)      addrInc = 7'h40;
    else if (oAddress == 7'h67) addrInc = 7'h00;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state          <= INIT8;
      enPrev         <= 1'b0;
      highCnt        <= '0;
      timeoutCnt     <= '0;
      hiNibble       <= 4'h0;
      hiRs           <= 1'b0;
      oByte          <= 8'h00;
      oIsData        <= 1'b0;
      oByteValid     <= 1'b0;
      oMode4Bit      <= 1'b0;
      oAddress       <= 7'h00;
      oDisplayOn     <= 1'b0;
      oClearPulse    <= 1'b0;
      oProtocolError <= 1'b0;
    end else begin
      enPrev      <= iLCD_Enabled;
      oByteValid  <= 1'b0;
      oClearPulse <= 1'b0;

      // Saturates at the threshold; only "long enough or not" matters.
      if (iLCD_Enabled) begin
        if (highCnt < HIGH_MIN) highCnt <= highCnt + 1'b1;
      end else begin
        highCnt <= '0;
      end

      if (shortWrite) oProtocolError <= 1'b1;

      case (state)
        INIT8: begin
          if (validWrite) begin
            if (iLCD_Data == 4'h3) begin
              state <= INIT8;
            end else if (iLCD_Data == 4'h2 && !iLCD_RegisterSelect) begin
              oMode4Bit <= 1'b1;
              state     <= HI;
            end else begin
              oProtocolError <= 1'b1;
            end
          end
        end

        HI: begin
          if (validWrite) begin
            hiNibble   <= iLCD_Data;
            hiRs       <= iLCD_RegisterSelect;
            timeoutCnt <= '0;
            state      <= LO;
          end
        end

        LO: begin
          if (validWrite) begin
            state <= HI;
            if (iLCD_RegisterSelect != hiRs) begin
              oProtocolError <= 1'b1;
            end else begin
              oByte      <= newByte;
              oIsData    <= hiRs;
              oByteValid <= 1'b1;
              if (hiRs) begin
                oAddress <= addrInc;
              end else if (newByte == 8'h01) begin
                oAddress    <= 7'h00;
                oClearPulse <= 1'b1;
              end else if (newByte == 8'h02 || newByte == 8'h03) begin
                oAddress <= 7'h00;
              end else if (newByte[7:3] == 5'b00001) begin
                oDisplayOn <= newByte[2];
              end else if (newByte[7]) begin
                oAddress <= newByte[6:0];
              end
            end
          end else if (timeoutCnt >= TO_LAST) begin
            oProtocolError <= 1'b1;
            state          <= HI;
          end else if (timeoutCnt != TO_MAX) begin
            timeoutCnt <= timeoutCnt + 1'b1;
          end
        end

        default: state <= INIT8;
      endcase
    end
  end

endmodule
